asi_regbank: RTL and testbench
==============================

// Module: asi_regbank
// PURPOSE
//  32-bit control/status register bank. Sits directly downstream of the 128->32 AXI register
//  adapter and consumes its REG WRITE / REG READ word ports. Each port uses a valid/ready
//  request-acknowledge handshake. Provides CTRL, STATUS, W1C interrupt, cycle-counter and
//  scratch registers, and drives a level interrupt to the core.
// PARAMETERS
//  AXI_SW    3             size field width (matches adapter)
//  REG_AW    20            byte-address width of register space
//  REG_DW    32            register data width
//  L         $clog2(REG_DW/8)  word-offset bits (=2); expected size code
//  IRQ_N     8             interrupt source count, 1..32
//  NSCRATCH  4             scratch registers, 1..64
//  CTRL_RST  32'h0         CTRL reset value
// PORTS
//  clk        in   1          clock
//  rst        in   1          asynchronous active-high reset
//  m_wsize    in   AXI_SW     write size; must equal L
//  m_waddr    in   REG_AW-L   write word address [REG_AW-1:L]
//  m_wdata    in   REG_DW     write data
//  m_wstrb    in   REG_DW/8   write byte strobes
//  m_wlast    in   1          last beat of burst; informational, no effect
//  m_wvalid   in   1          write request, held until m_wready
//  m_wready   out  1          write ack, one-cycle pulse
//  m_rsize    in   AXI_SW     read size; must equal L
//  m_raddr    in   REG_AW-L   read word address [REG_AW-1:L]
//  m_rvalid   in   1          read request, held until m_rready
//  m_rdata    out  REG_DW     read data, valid while m_rready=1
//  m_rready   out  1          read ack/data-valid, one-cycle pulse
//  hw_status  in   REG_DW     live status from core
//  hw_irq_set in   IRQ_N      per-source interrupt set pulses
//  ctrl_o     out  REG_DW     CTRL register contents
//  irq        out  1          registered |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Register map (word index = address[REG_AW-1:L]):
//   0 CTRL RW | 1 STATUS RO | 2 IRQ_STAT W1C [IRQ_N-1:0] | 3 IRQ_EN RW [IRQ_N-1:0]
//   4 CYCLE_CNT RO | 5..4+NSCRATCH SCRATCH RW
//   Unused upper bits read 0.
//  Reset (async, rst=1):
//   FSM=IDLE, m_wready=0, m_rready=0, m_rdata=0, CTRL=ctrl_o=CTRL_RST,
//   IRQ_STAT=IRQ_EN=CYCLE_CNT=SCRATCH=0, irq=0.
//   A reset mid-transaction discards it; no ack is issued for it.
//  FSM IDLE/WACK/RACK; all outputs are registered:
//   IDLE: m_wvalid -> capture waddr/wdata/wstrb/wsize, go WACK.
//         Else m_rvalid -> capture raddr/rsize, go RACK.
//         Both valid at once: the write wins; the read is served on the next IDLE pass.
//   WACK: m_wready=1 for exactly 1 cycle; commit the write on the same edge; go IDLE.
//   RACK: m_rready=1 for exactly 1 cycle with m_rdata; go IDLE.
//   Latency: request seen in IDLE at edge N -> ack high in cycle N+1.
//   Throughput: one transaction per 2 cycles. The requester drops valid after seeing the ack.
//  Write rules:
//   Byte k updates only if wstrb[k]=1. RW regs: byte merge.
//   IRQ_STAT: strobed bytes clear the bits written 1.
//   RO, out-of-range index, or wsize!=L: acked, with no state change.
//  Read rules:
//   Data is sampled at the IDLE->RACK edge.
//   STATUS = hw_status sampled at that edge.
//   Out-of-range index or rsize!=L: m_rdata=0.
//  IRQ_STAT: bit i is set by hw_irq_set[i]=1. Set beats a same-cycle W1C clear.
//   irq updates one cycle after IRQ_STAT/IRQ_EN change.
//  CYCLE_CNT: +1 every cycle after reset; wraps 32'hFFFF_FFFF -> 0; writes are ignored.
//  m_rdata holds its last value between acks.
// TESTING
//  1 Reset: rst=1 mid-RACK -> m_rready=0, m_rdata=0, ctrl_o=CTRL_RST, irq=0; no stray ack after release.
//  2 Write CTRL (waddr word 0) with wdata=32'hA5A5_1234, wstrb=4'b0101
//    -> m_wready pulses at N+1; ctrl_o=32'h00A5_0034.
//  3 Read SCRATCH[2] after writing 32'hCAFE_F00D -> m_rready pulses at N+1 with m_rdata=32'hCAFE_F00D;
//    read index 5+NSCRATCH -> 0.
//  4 hw_irq_set[3] pulse with IRQ_EN=8'h08 -> irq=1 two cycles later.
//    W1C 32'h8 on the same cycle as another set pulse -> bit 3 stays 1.
//    W1C alone -> irq=0 one cycle after the clear.
//  5 m_wvalid and m_rvalid rise together -> m_wready at N+1, m_rready at N+3; read sees the new data.
//  6 Write with wsize=3'd3 to CTRL -> acked, ctrl_o unchanged.
//    Force CYCLE_CNT=32'hFFFF_FFFF -> reads 0 the next cycle.

Source files
------------

// File: rtl/asi_regbank.sv
// asi_regbank: 32-bit control/status register bank behind the 128->32 AXI register adapter.
// One request is served per two cycles: IDLE accepts it and WACK/RACK issues the one-cycle ack.
// Writes commit at the edge that leaves WACK. Read data is sampled at the edge that enters RACK.
module asi_regbank #(
    parameter int                AXI_SW   = 3,
    parameter int                REG_AW   = 20,
    parameter int                REG_DW   = 32,
    parameter int                L        = $clog2(REG_DW/8),
    parameter int                IRQ_N    = 8,
    parameter int                NSCRATCH = 4,
    parameter logic [REG_DW-1:0] CTRL_RST = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_SW-1:0]     m_wsize,
    input  logic [REG_AW-L-1:0]   m_waddr,
    input  logic [REG_DW-1:0]     m_wdata,
    input  logic [REG_DW/8-1:0]   m_wstrb,
    input  logic                  m_wlast,
    input  logic                  m_wvalid,
    output logic                  m_wready,
    input  logic [AXI_SW-1:0]     m_rsize,
    input  logic [REG_AW-L-1:0]   m_raddr,
    input  logic                  m_rvalid,
    output logic [REG_DW-1:0]     m_rdata,
    output logic                  m_rready,
    input  logic [REG_DW-1:0]     hw_status,
    input  logic [IRQ_N-1:0]      hw_irq_set,
    output logic [REG_DW-1:0]     ctrl_o,
    output logic                  irq
);

    localparam int                WAW     = REG_AW - L;
    localparam int                SB      = REG_DW / 8;
    localparam logic [AXI_SW-1:0] SIZE_OK = AXI_SW'(L);

    typedef enum logic [1:0] {IDLE, WACK, RACK} state_t;

    state_t            state_q, state_d;
    logic              wready_q, wready_d;
    logic              rready_q, rready_d;
    logic [REG_DW-1:0] rdata_q, rdata_d;
    logic [WAW-1:0]    waddr_q, waddr_d;
    logic [REG_DW-1:0] wdata_q, wdata_d;
    logic [SB-1:0]     wstrb_q, wstrb_d;
    logic              wsize_ok_q, wsize_ok_d;
    logic [REG_DW-1:0] ctrl_q, ctrl_d;
    logic [IRQ_N-1:0]  irq_stat_q, irq_stat_d;
    logic [IRQ_N-1:0]  irq_en_q, irq_en_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [REG_DW-1:0] scratch_q [NSCRATCH];
    logic [REG_DW-1:0] scratch_d [NSCRATCH];
    logic              irq_q, irq_d;
    logic [IRQ_N-1:0]  w1c_mask;
    logic [REG_DW-1:0] rd_word;

    // m_wlast only marks burst ends; every beat is handled identically.
    logic unused_wlast;
    assign unused_wlast = m_wlast;

    // Expand byte strobes into a per-bit mask.
    function automatic logic [REG_DW-1:0] strb_mask(input logic [SB-1:0] strb);
        logic [REG_DW-1:0] m;
        for (int k = 0; k < SB; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

    // Replace only the strobed bytes of a register.
    function automatic logic [REG_DW-1:0] byte_merge(input logic [REG_DW-1:0] old_v,
                                                     input logic [REG_DW-1:0] new_v,
                                                     input logic [SB-1:0]     strb);
        logic [REG_DW-1:0] m;
        m = strb_mask(strb);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // Read mux over the register map; bad size or unmapped index returns zero.
    always_comb begin
        rd_word = '0;
        if (m_rsize == SIZE_OK) begin
            if (m_raddr == WAW'(0)) rd_word = ctrl_q;
            if (m_raddr == WAW'(1)) rd_word = hw_status;
            if (m_raddr == WAW'(2)) rd_word = REG_DW'(irq_stat_q);
            if (m_raddr == WAW'(3)) rd_word = REG_DW'(irq_en_q);
            if (m_raddr == WAW'(4)) rd_word = REG_DW'(cycle_cnt_q);
            for (int i = 0; i < NSCRATCH; i++) begin
                if (m_raddr == WAW'(i + 5)) rd_word = scratch_q[i];
            end
        end
    end

    // Handshake FSM, write commit, interrupt and counter next-state.
    always_comb begin
        state_d    = state_q;
        wready_d   = 1'b0;
        rready_d   = 1'b0;
        rdata_d    = rdata_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wsize_ok_d = wsize_ok_q;
        ctrl_d     = ctrl_q;
        irq_en_d   = irq_en_q;
        scratch_d  = scratch_q;
        w1c_mask   = '0;
        case (state_q)
            IDLE: begin
                if (m_wvalid) begin
                    waddr_d    = m_waddr;
                    wdata_d    = m_wdata;
                    wstrb_d    = m_wstrb;
                    wsize_ok_d = (m_wsize == SIZE_OK);
                    wready_d   = 1'b1;
                    state_d    = WACK;
                end else if (m_rvalid) begin
                    rdata_d  = rd_word;
                    rready_d = 1'b1;
                    state_d  = RACK;
                end
            end
            WACK: begin
                state_d = IDLE;
                if (wsize_ok_q) begin
                    if (waddr_q == WAW'(0)) ctrl_d = byte_merge(ctrl_q, wdata_q, wstrb_q);
                    if (waddr_q == WAW'(2)) w1c_mask = IRQ_N'(wdata_q & strb_mask(wstrb_q));
                    if (waddr_q == WAW'(3))
                        irq_en_d = IRQ_N'(byte_merge(REG_DW'(irq_en_q), wdata_q, wstrb_q));
                    for (int i = 0; i < NSCRATCH; i++) begin
                        if (waddr_q == WAW'(i + 5))
                            scratch_d[i] = byte_merge(scratch_q[i], wdata_q, wstrb_q);
                    end
                end
            end
            RACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A set pulse wins over a W1C clear of the same bit.
        irq_stat_d  = (irq_stat_q & ~w1c_mask) | hw_irq_set;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        irq_d       = |(irq_stat_q & irq_en_q);
    end

    // State registers; reset drops any in-flight transaction without acking it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rdata_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wsize_ok_q  <= 1'b0;
            ctrl_q      <= CTRL_RST;
            irq_stat_q  <= '0;
            irq_en_q    <= '0;
            cycle_cnt_q <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NSCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wready_q    <= wready_d;
            rready_q    <= rready_d;
            rdata_q     <= rdata_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wsize_ok_q  <= wsize_ok_d;
            ctrl_q      <= ctrl_d;
            irq_stat_q  <= irq_stat_d;
            irq_en_q    <= irq_en_d;
            cycle_cnt_q <= cycle_cnt_d;
            irq_q       <= irq_d;
            scratch_q   <= scratch_d;
        end
    end

    assign m_wready = wready_q;
    assign m_rready = rready_q;
    assign m_rdata  = rdata_q;
    assign ctrl_o   = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_asi_regbank.sv
// Testbench for asi_regbank: bus tasks drive requests, and a scoreboard queue holds expected read data.
module tb_asi_regbank;

    localparam int WAW   = 18;
    localparam int IRQ_N = 8;
    localparam int NS    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        m_wsize = 3'd2;
    logic [WAW-1:0]    m_waddr = '0;
    logic [31:0]       m_wdata = '0;
    logic [3:0]        m_wstrb = '0;
    logic              m_wlast = 1'b0;
    logic              m_wvalid = 1'b0;
    logic              m_wready;
    logic [2:0]        m_rsize = 3'd2;
    logic [WAW-1:0]    m_raddr = '0;
    logic              m_rvalid = 1'b0;
    logic [31:0]       m_rdata;
    logic              m_rready;
    logic [31:0]       hw_status = '0;
    logic [IRQ_N-1:0]  hw_irq_set = '0;
    logic [31:0]       ctrl_o;
    logic              irq;

    asi_regbank dut (
        .clk        (clk),
        .rst        (rst),
        .m_wsize    (m_wsize),
        .m_waddr    (m_waddr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wlast    (m_wlast),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_rsize    (m_rsize),
        .m_raddr    (m_raddr),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .m_rready   (m_rready),
        .hw_status  (hw_status),
        .hw_irq_set (hw_irq_set),
        .ctrl_o     (ctrl_o),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    bit      mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Scoreboard: every read ack pops the oldest expected word.
    always @(negedge clk) begin
        if (mon_en && m_rready) begin
            if (exp_q.size() == 0) begin
                check_eq("rd_unexpected_ack", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check_eq(e.tag, m_rdata, e.exp);
            end
        end
    end

    task automatic bus_write(input logic [WAW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] sz);
        int lat = 0;
        @(negedge clk);
        m_waddr = a; m_wdata = d; m_wstrb = s; m_wsize = sz; m_wlast = 1'b1; m_wvalid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (m_wready) begin
                lat = n;
                break;
            end
        end
        m_wvalid = 1'b0; m_wlast = 1'b0;
        check_eq("wr_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check_eq("wr_ack_pulse", {31'b0, m_wready}, 32'd0);
    endtask

    task automatic bus_read(input logic [WAW-1:0] a, input logic [2:0] sz,
                            input logic [31:0] exp, input string tag);
        int lat = 0;
        exp_q.push_back('{tag, exp});
        @(negedge clk);
        m_raddr = a; m_rsize = sz; m_rvalid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (m_rready) begin
                lat = n;
                break;
            end
        end
        m_rvalid = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'd1);
        @(negedge clk);
        check_eq({tag, "_ack_pulse"}, {31'b0, m_rready}, 32'd0);
        check_eq({tag, "_hold"}, m_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int stray;
        int wc;
        int rc;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_wready", {31'b0, m_wready}, 32'd0);
        check_eq("rst_rready", {31'b0, m_rready}, 32'd0);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_ctrl", ctrl_o, 32'h0);
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a read ack
        bus_write(18'd0, 32'h1111_2222, 4'hF, 3'd2);
        check_eq("ctrl_full_write", ctrl_o, 32'h1111_2222);
        @(negedge clk);
        m_raddr = 18'd0; m_rsize = 3'd2; m_rvalid = 1'b1;
        @(negedge clk);
        check_eq("rack_before_rst", {31'b0, m_rready}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_rready", {31'b0, m_rready}, 32'd0);
        check_eq("midrst_rdata", m_rdata, 32'd0);
        check_eq("midrst_ctrl", ctrl_o, 32'h0);
        check_eq("midrst_irq", {31'b0, irq}, 32'd0);
        m_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (m_rready || m_wready) stray++;
        end
        check_eq("rst_no_stray_ack", 32'(stray), 32'd0);
        mon_en = 1'b1;

        // CTRL byte-strobed write
        bus_write(18'd0, 32'hA5A5_1234, 4'b0101, 3'd2);
        check_eq("ctrl_strobed", ctrl_o, 32'h00A5_0034);
        bus_read(18'd0, 3'd2, 32'h00A5_0034, "rd_ctrl");

        // STATUS, scratch, out-of-range
        hw_status = 32'h1357_9BDF;
        bus_read(18'd1, 3'd2, 32'h1357_9BDF, "rd_status");
        bus_write(18'd7, 32'hCAFE_F00D, 4'hF, 3'd2);
        bus_read(18'd7, 3'd2, 32'hCAFE_F00D, "rd_scratch2");
        bus_read(18'(5 + NS), 3'd2, 32'h0, "rd_out_of_range");
        bus_write(18'd5, 32'h1122_3344, 4'hF, 3'd2);
        bus_write(18'd5, 32'hAABB_CCDD, 4'b1000, 3'd2);
        bus_read(18'd5, 3'd2, 32'hAA22_3344, "rd_scratch0_merge");
        bus_write(18'(5 + NS), 32'hFFFF_FFFF, 4'hF, 3'd2);
        bus_read(18'd5, 3'd2, 32'hAA22_3344, "rd_scratch0_no_alias");

        // Interrupts
        bus_write(18'd3, 32'h0000_0008, 4'hF, 3'd2);
        bus_read(18'd3, 3'd2, 32'h0000_0008, "rd_irq_en");
        @(negedge clk); hw_irq_set = 8'h08;
        @(negedge clk); hw_irq_set = 8'h00;
        check_eq("irq_lat1", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check_eq("irq_lat2", {31'b0, irq}, 32'd1);
        // W1C racing a set of the same bit
        @(negedge clk);
        m_waddr = 18'd2; m_wdata = 32'h8; m_wstrb = 4'hF; m_wsize = 3'd2; m_wvalid = 1'b1;
        @(negedge clk);
        check_eq("w1c_race_ack", {31'b0, m_wready}, 32'd1);
        m_wvalid = 1'b0; hw_irq_set = 8'h08;
        @(negedge clk); hw_irq_set = 8'h00;
        bus_read(18'd2, 3'd2, 32'h8, "rd_stat_set_wins");
        check_eq("irq_after_race", {31'b0, irq}, 32'd1);
        // W1C alone
        @(negedge clk);
        m_waddr = 18'd2; m_wdata = 32'h8; m_wstrb = 4'hF; m_wsize = 3'd2; m_wvalid = 1'b1;
        @(negedge clk);
        check_eq("w1c_ack", {31'b0, m_wready}, 32'd1);
        m_wvalid = 1'b0;
        @(negedge clk);
        check_eq("irq_clr_lat0", {31'b0, irq}, 32'd1);
        @(negedge clk);
        check_eq("irq_clr_lat1", {31'b0, irq}, 32'd0);
        bus_read(18'd2, 3'd2, 32'h0, "rd_stat_cleared");
        // Masked source and strobe-gated clear
        @(negedge clk); hw_irq_set = 8'h01;
        @(negedge clk); hw_irq_set = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("irq_masked", {31'b0, irq}, 32'd0);
        bus_write(18'd2, 32'h1, 4'b1110, 3'd2);
        bus_read(18'd2, 3'd2, 32'h1, "rd_w1c_unstrobed");
        bus_write(18'd2, 32'h1, 4'b0001, 3'd2);
        bus_read(18'd2, 3'd2, 32'h0, "rd_w1c_strobed");

        // Simultaneous write and read to the same register
        exp_q.push_back('{"rd_both_new_data", 32'hDEAD_BEEF});
        @(negedge clk);
        m_waddr = 18'd6; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wsize = 3'd2; m_wvalid = 1'b1;
        m_raddr = 18'd6; m_rsize = 3'd2; m_rvalid = 1'b1;
        wc = 0; rc = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (m_wready && wc == 0) begin wc = n; m_wvalid = 1'b0; end
            if (m_rready && rc == 0) begin rc = n; m_rvalid = 1'b0; end
            if (rc != 0) break;
        end
        m_wvalid = 1'b0; m_rvalid = 1'b0;
        check_eq("both_wr_latency", 32'(wc), 32'd1);
        check_eq("both_rd_latency", 32'(rc), 32'd3);
        @(negedge clk);

        // Bad size
        bus_write(18'd0, 32'hFFFF_FFFF, 4'hF, 3'd3);
        check_eq("ctrl_bad_wsize", ctrl_o, 32'h00A5_0034);
        bus_read(18'd0, 3'd3, 32'h0, "rd_bad_rsize");

        // Cycle counter wrap
        @(negedge clk);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        bus_read(18'd4, 3'd2, 32'h0, "rd_cnt_wrap");
        bus_read(18'd4, 3'd2, 32'h3, "rd_cnt_incr");

        repeat (2) @(negedge clk);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
